// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller between the processor DMEM port and a
// word-wide SRAM without byte enables. Sub-word stores are read-modify-write.
// Vectors are declared [31:0]; the big-endian bit i of the interface
// description is vector bit 31-i, so byte lane 0 is [31:24] and addr bits
// [1:0] select the byte within a word.
module dmem_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        proc_valid,
    input  logic [31:0] proc_addr,
    input  logic [31:0] proc_wdata,
    input  logic        proc_we,
    input  logic        proc_byte,
    input  logic        proc_half,
    input  logic        proc_sext,
    output logic        proc_ready,
    output logic [31:0] proc_rdata,
    output logic        proc_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    // Last wait count before the abort: mem_req stays up MEM_TIMEOUT cycles.
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_RMW_WR,
        S_WR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;     // store data, later the merged RMW word
    logic          byte_q, byte_d;
    logic          half_q, half_d;
    logic          sext_q, sext_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] wait_q, wait_d;

    logic          misaligned;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    // Alignment check on the live request; a byte access can never be misaligned.
    always_comb begin
        misaligned = 1'b0;
        if (!proc_byte) begin
            if (proc_half) misaligned = proc_addr[0];
            else           misaligned = (proc_addr[1:0] != 2'b00);
        end
    end

    // Lane extraction with sign/zero extension, and lane merge for RMW stores.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[31:24];
            2'd1:    rd_byte = mem_rdata[23:16];
            2'd2:    rd_byte = mem_rdata[15:8];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        if (byte_q)      load_ext = {{24{sext_q & rd_byte[7]}}, rd_byte};
        else if (half_q) load_ext = {{16{sext_q & rd_half[15]}}, rd_half};
        else             load_ext = mem_rdata;

        merged = mem_rdata;
        if (byte_q) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = wdata_q[15:0];
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    // State and datapath registers; reset abandons any in-flight access at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            sext_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            half_q  <= half_d;
            sext_q  <= sext_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; rdata/err are only non-zero during the DONE cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        half_d  = half_q;
        sext_d  = sext_q;
        rdata_d = '0;
        err_d   = 1'b0;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (proc_valid) begin
                    addr_d  = proc_addr;
                    wdata_d = proc_wdata;
                    byte_d  = proc_byte;
                    half_d  = proc_half & ~proc_byte;
                    sext_d  = proc_sext;
                    wait_d  = '0;
                    if (misaligned) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (!proc_we) begin
                        state_d = S_RD;
                    end else if (proc_byte || proc_half) begin
                        state_d = S_RMW_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD, S_RMW_RD, S_RMW_WR, S_WR: begin
                if (mem_ack) begin
                    wait_d = '0;
                    if (state_q == S_RD) begin
                        rdata_d = load_ext;
                        state_d = S_DONE;
                    end else if (state_q == S_RMW_RD) begin
                        wdata_d = merged;
                        state_d = S_RMW_WR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (wait_q == TMO_LAST) begin
                    // Abort: an RMW read timeout goes straight to DONE, never writing.
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        proc_ready = (state_q == S_DONE);
        mem_req    = (state_q == S_RD) || (state_q == S_RMW_RD) ||
                     (state_q == S_RMW_WR) || (state_q == S_WR);
        mem_we     = (state_q == S_RMW_WR) || (state_q == S_WR);
    end

    assign mem_addr   = addr_q[31:2];
    assign mem_wdata  = wdata_q;
    assign proc_rdata = rdata_q;
    assign proc_err   = err_q;
    assign stall      = proc_valid & ~proc_ready;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural SRAM responder and a
// scoreboard of expected completions.
module tb_dmem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_valid;
    logic [31:0] proc_addr;
    logic [31:0] proc_wdata;
    logic        proc_we;
    logic        proc_byte;
    logic        proc_half;
    logic        proc_sext;
    logic        proc_ready;
    logic [31:0] proc_rdata;
    logic        proc_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory responder controls
    logic [31:0] mem [0:255];
    int wait_cfg = 0;
    bit no_ack   = 0;
    bit hold_wr  = 0;
    bit spur_ack = 0;
    int wcnt     = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          rc;     // cycle of proc_ready (capture edge = 0)
        int          req;    // number of cycles with mem_req high
        logic        we;     // a write is expected
        logic [31:0] wdata;
        logic [29:0] maddr;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    dmem_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .proc_valid (proc_valid),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_we    (proc_we),
        .proc_byte  (proc_byte),
        .proc_half  (proc_half),
        .proc_sext  (proc_sext),
        .proc_ready (proc_ready),
        .proc_rdata (proc_rdata),
        .proc_err   (proc_err),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    // SRAM model: acks after wait_cfg wait cycles, ack valid for one cycle.
    always @(negedge clock) begin
        if (mem_ack) wcnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (!mem_req) begin
            wcnt = 0;
            if (spur_ack) mem_ack = 1'b1;
        end else if (!no_ack && !(hold_wr && mem_we)) begin
            if (wcnt == wait_cfg) begin
                mem_ack = 1'b1;
                if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
                else        mem_rdata = mem[mem_addr[7:0]];
            end else begin
                wcnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(logic [31:0] rdata, logic err, int rc, int req,
                                logic we, logic [31:0] wdata, logic [29:0] maddr);
        exp_t e;
        e.rdata = rdata; e.err = err; e.rc = rc; e.req = req;
        e.we = we; e.wdata = wdata; e.maddr = maddr;
        return e;
    endfunction

    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input logic we, input logic b, input logic h, input logic s,
                           input exp_t e);
        int   rc = 0;
        int   req_cnt = 0;
        bit   got = 0;
        bit   stall_bad = 0;
        logic we_seen = 1'b0;
        logic [31:0] wd_seen = 32'h0;
        logic [29:0] ma_seen = 30'h0;
        logic [31:0] rd = 32'h0;
        logic er = 1'b0;
        exp_t x;
        @(negedge clock);
        proc_valid = 1'b1; proc_addr = addr; proc_wdata = wd;
        proc_we = we; proc_byte = b; proc_half = h; proc_sext = s;
        sb.push_back(e);
        #1;
        if (stall !== 1'b1) stall_bad = 1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clock); #1;
            if (mem_req === 1'b1) begin
                req_cnt++;
                ma_seen = mem_addr;
                if (mem_we === 1'b1) begin
                    we_seen = 1'b1;
                    wd_seen = mem_wdata;
                end
            end
            if (proc_ready === 1'b1) begin
                got = 1; rc = cyc; rd = proc_rdata; er = proc_err;
                if (stall !== 1'b0) stall_bad = 1;
                break;
            end else if (stall !== 1'b1) begin
                stall_bad = 1;
            end
        end
        proc_valid = 1'b0;
        x = sb.pop_front();
        n_cmp++;
        assert (got) else begin
            n_bad++;
            $error("FAIL %s.ready: observed no proc_ready within 40 cycles, expected one at cycle %0d", tag, x.rc);
        end
        if (got) begin
            chk({tag, ".rdata"}, rd, x.rdata);
            chk({tag, ".err"}, {31'h0, er}, {31'h0, x.err});
            chk({tag, ".cycle"}, rc, x.rc);
            chk({tag, ".reqcyc"}, req_cnt, x.req);
            chk({tag, ".we"}, {31'h0, we_seen}, {31'h0, x.we});
            chk({tag, ".stall"}, {31'h0, stall_bad}, 32'h0);
            if (x.we) chk({tag, ".wdata"}, wd_seen, x.wdata);
            if (x.req > 0) chk({tag, ".maddr"}, {2'b00, ma_seen}, {2'b00, x.maddr});
        end
        $display("txn %s: ready@%0d rdata=%h err=%b reqcyc=%0d", tag, rc, rd, er, req_cnt);
        @(posedge clock);
    endtask

    initial begin
        bit spur_bad;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b0;
        proc_valid = 1'b0; proc_addr = 32'h0; proc_wdata = 32'h0;
        proc_we = 1'b0; proc_byte = 1'b0; proc_half = 1'b0; proc_sext = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        #2;
        chk("reset.ready", {31'h0, proc_ready}, 32'h0);
        chk("reset.req",   {31'h0, mem_req},    32'h0);
        chk("reset.we",    {31'h0, mem_we},     32'h0);
        chk("reset.err",   {31'h0, proc_err},   32'h0);
        chk("reset.rdata", proc_rdata,          32'h0);
        chk("reset.maddr", {2'b00, mem_addr},   32'h0);
        chk("reset.wdata", mem_wdata,           32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Loads
        mem[8'h40] = 32'hDEADBEEF; wait_cfg = 2;
        run_txn("wld_wait2", 32'h100, 32'h0, 0, 0, 0, 0, mk(32'hDEADBEEF, 0, 4, 3, 0, 0, 30'h40));
        wait_cfg = 0;
        mem[8'h40] = 32'h123456F0;
        run_txn("bld_sext", 32'h103, 32'h0, 0, 1, 0, 1, mk(32'hFFFFFFF0, 0, 2, 1, 0, 0, 30'h40));
        run_txn("bld_zext", 32'h103, 32'h0, 0, 1, 0, 0, mk(32'h000000F0, 0, 2, 1, 0, 0, 30'h40));
        mem[8'h40] = 32'h12348001;
        run_txn("hld_sext", 32'h102, 32'h0, 0, 0, 1, 1, mk(32'hFFFF8001, 0, 2, 1, 0, 0, 30'h40));
        run_txn("bld_lane1", 32'h101, 32'h0, 0, 1, 0, 1, mk(32'h00000034, 0, 2, 1, 0, 0, 30'h40));
        mem[8'h40] = 32'h80011234;
        run_txn("hld_lane0", 32'h100, 32'h0, 0, 0, 1, 0, mk(32'h00008001, 0, 2, 1, 0, 0, 30'h40));

        // Stores
        mem[8'h80] = 32'h11223344;
        run_txn("bst", 32'h201, 32'hFFFFFFAA, 1, 1, 0, 0, mk(32'h0, 0, 3, 2, 1, 32'h11AA3344, 30'h80));
        chk("bst.mem", mem[8'h80], 32'h11AA3344);
        wait_cfg = 1;
        run_txn("hst_wait1", 32'h202, 32'hFFFFBEEF, 1, 0, 1, 0, mk(32'h0, 0, 5, 4, 1, 32'h11AABEEF, 30'h80));
        chk("hst.mem", mem[8'h80], 32'h11AABEEF);
        wait_cfg = 0;
        run_txn("wst", 32'h204, 32'hCAFEF00D, 1, 0, 0, 0, mk(32'h0, 0, 2, 1, 1, 32'hCAFEF00D, 30'h81));
        chk("wst.mem", mem[8'h81], 32'hCAFEF00D);

        // Misaligned
        run_txn("mis_hst", 32'h203, 32'h1234, 1, 0, 1, 0, mk(32'h0, 1, 1, 0, 0, 0, 0));
        run_txn("mis_wld", 32'h001, 32'h0, 0, 0, 0, 0, mk(32'h0, 1, 1, 0, 0, 0, 0));

        // Timeouts (MEM_TIMEOUT = 4)
        no_ack = 1;
        mem[8'hC0] = 32'h55667788;
        run_txn("tmo_wld", 32'h300, 32'h0, 0, 0, 0, 0, mk(32'h0, 1, 5, 4, 0, 0, 30'hC0));
        run_txn("tmo_bst", 32'h301, 32'h99, 1, 1, 0, 0, mk(32'h0, 1, 5, 4, 0, 0, 30'hC0));
        chk("tmo_bst.mem", mem[8'hC0], 32'h55667788);
        no_ack = 0;

        // Ack without a request must be ignored
        spur_ack = 1; spur_bad = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (proc_ready !== 1'b0 || mem_req !== 1'b0) spur_bad = 1;
        end
        spur_ack = 0;
        chk("spurious_ack", {31'h0, spur_bad}, 32'h0);
        $display("txn spurious_ack: idle_disturbed=%b", spur_bad);

        // Asynchronous reset while RMW write is pending
        hold_wr = 1;
        @(negedge clock);
        proc_valid = 1'b1; proc_addr = 32'h202; proc_wdata = 32'h1234;
        proc_we = 1'b1; proc_byte = 1'b0; proc_half = 1'b1; proc_sext = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_mid.pre_req", {31'h0, mem_req}, 32'h1);
        chk("rst_mid.pre_we",  {31'h0, mem_we},  32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.req",   {31'h0, mem_req},    32'h0);
        chk("rst_mid.we",    {31'h0, mem_we},     32'h0);
        chk("rst_mid.ready", {31'h0, proc_ready}, 32'h0);
        $display("txn rst_mid: req=%b we=%b ready=%b", mem_req, mem_we, proc_ready);
        proc_valid = 1'b0; hold_wr = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk("rst_mid.mem", mem[8'h80], 32'h11AABEEF);

        run_txn("wld_after_rst", 32'h100, 32'h0, 0, 0, 0, 0, mk(32'h80011234, 0, 2, 1, 0, 0, 30'h40));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
